cpu_step_ctrl: RTL and testbench

CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

---
 rtl/cpu_step_ctrl_pkg.sv | 25 ++
 rtl/cpu_step_ctrl_btn_debounce.sv | 30 +++
 rtl/cpu_step_ctrl.sv | 106 ++++++++++
 tb/tb_cpu_step_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_step_ctrl_pkg.sv
// Shared encodings for the CPU single-step / run controller.
// Holds FSM state codes, mode codes and the mode-to-state target helper.
package cpu_step_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT       = 2'b00,
        ST_RUN        = 2'b01,
        ST_STEP_ARMED = 2'b10,
        ST_STEP_HELD  = 2'b11
    } state_t;

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    // Entering STEP with the button already down must wait for its release.
    function automatic state_t mode_target(input logic [1:0] m, input logic held);
        case (m)
            MODE_RUN:  return ST_RUN;
            MODE_STEP: return held ? ST_STEP_HELD : ST_STEP_ARMED;
            default:   return ST_HALT;
        endcase
    endfunction

endpackage

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// Push-button debouncer: the accepted level follows din only after
// DEBOUNCE_CYCLES consecutive samples that differ from it.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt  <= '0;
            dout <= din;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable controller: HALT, free RUN on slow-clock ticks, or one
// enable pulse per debounced push-button press in STEP mode.
module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_in,
    input  logic        step_btn,
    input  logic [1:0]  mode,
    output logic        cpu_en,
    output logic [31:0] step_count,
    output logic [1:0]  state
);

    logic [SYNC_STAGES-1:0] tick_sync;
    logic [SYNC_STAGES-1:0] btn_sync;
    logic [SYNC_STAGES:0]   warm;
    logic                   tick_prev;
    logic                   tick_rise;
    logic                   btn_level;
    logic                   level_prev;
    logic                   press_rise;
    logic [1:0]             mode_q;
    logic                   pulse_next;
    state_t                 state_q;

    assign state = state_q;

    // warm keeps a level that is already high at reset release from looking
    // like an edge: tick_rise is only trusted once tick_prev holds a real sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_sync  <= '0;
            btn_sync   <= '0;
            warm       <= '0;
            tick_prev  <= 1'b0;
            tick_rise  <= 1'b0;
            level_prev <= 1'b0;
            press_rise <= 1'b0;
            mode_q     <= MODE_HALT;
        end else begin
            tick_sync[0] <= tick_in;
            btn_sync[0]  <= step_btn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                tick_sync[i] <= tick_sync[i-1];
                btn_sync[i]  <= btn_sync[i-1];
            end
            warm       <= {warm[SYNC_STAGES-1:0], 1'b1};
            tick_prev  <= tick_sync[SYNC_STAGES-1];
            tick_rise  <= warm[SYNC_STAGES] & tick_sync[SYNC_STAGES-1] & ~tick_prev;
            level_prev <= btn_level;
            press_rise <= btn_level & ~level_prev;
            mode_q     <= mode;
        end
    end

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_sync[SYNC_STAGES-1]),
        .dout (btn_level)
    );

    // The !cpu_en terms keep two enables from ever landing back to back.
    always_comb begin
        pulse_next = 1'b0;
        case (state_q)
            ST_RUN:        pulse_next = tick_rise & ~cpu_en;
            ST_STEP_ARMED: pulse_next = (mode_q == MODE_STEP) & press_rise & ~cpu_en;
            default:       pulse_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_HALT;
            cpu_en     <= 1'b0;
            step_count <= '0;
        end else begin
            case (state_q)
                ST_HALT: state_q <= mode_target(mode_q, btn_level);
                ST_RUN: begin
                    if (mode_q != MODE_RUN) state_q <= mode_target(mode_q, 1'b0);
                end
                ST_STEP_ARMED: begin
                    if (mode_q != MODE_STEP)  state_q <= mode_target(mode_q, 1'b0);
                    else if (pulse_next)      state_q <= ST_STEP_HELD;
                end
                ST_STEP_HELD: begin
                    if (mode_q != MODE_STEP)  state_q <= mode_target(mode_q, 1'b0);
                    else if (!btn_level)      state_q <= ST_STEP_ARMED;
                end
                default: state_q <= ST_HALT;
            endcase
            cpu_en     <= pulse_next;
            step_count <= step_count + 32'(pulse_next);
        end
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with short debounce and two sync stages.
// Expected values are hand-derived from the pipeline depth (tick -> enable = 4).
module tb_cpu_step_ctrl;

    logic        clk;
    logic        rst;
    logic        tick_in;
    logic        step_btn;
    logic [1:0]  mode;
    logic        cpu_en;
    logic [31:0] step_count;
    logic [1:0]  state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int last_pulse_cyc = -1;
    int consec_err = 0;
    logic prev_en = 1'b0;
    int rc;
    int base;

    cpu_step_ctrl #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_in    (tick_in),
        .step_btn   (step_btn),
        .mode       (mode),
        .cpu_en     (cpu_en),
        .step_count (step_count),
        .state      (state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // pulse monitor: enables last a full cycle, so sample mid-cycle
    always @(negedge clk) begin
        if (cpu_en === 1'b1) begin
            pulse_cnt++;
            last_pulse_cyc = cyc;
            if (prev_en === 1'b1) consec_err++;
        end
        prev_en = cpu_en;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        tick_in = 1'b0;
        step_btn = 1'b0;
        mode = 2'b00;
        #1 rst = 1'b1;
        step(2);
        check("reset_cpu_en", {31'b0, cpu_en}, 32'd0);
        check("reset_step_count", step_count, 32'd0);
        check("reset_state", {30'b0, state}, 32'd0);
        rst = 1'b0;
        step(5);

        // HALT: ticks and a press must not enable the CPU
        for (int i = 0; i < 4; i++) begin
            tick_in = ~tick_in;
            step(10);
        end
        step_btn = 1'b1;
        step(10);
        step_btn = 1'b0;
        step(10);
        check("halt_pulses", pulse_cnt, 32'd0);
        check("halt_step_count", step_count, 32'd0);
        check("halt_state", {30'b0, state}, 32'd0);

        // RUN: five tick rises, each enable 4 cycles after the rise
        mode = 2'b01;
        step(3);
        check("run_state", {30'b0, state}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick_in = 1'b1;
            rc = cyc;
            step(10);
            check($sformatf("run_latency_%0d", k), last_pulse_cyc - rc, 32'd4);
            check($sformatf("run_pulses_%0d", k), pulse_cnt, k + 1);
            tick_in = 1'b0;
            step(10);
        end
        check("run_step_count", step_count, 32'd5);

        // mode 01->10 arriving with the tick edge: one RUN pulse, then armed
        tick_in = 1'b1;
        rc = cyc;
        step(2);
        mode = 2'b10;
        step(8);
        check("switch_pulses", pulse_cnt, 32'd6);
        check("switch_latency", last_pulse_cyc - rc, 32'd4);
        check("switch_state", {30'b0, state}, 32'd2);
        tick_in = 1'b0;
        step(10);
        tick_in = 1'b1;
        step(10);
        tick_in = 1'b0;
        step(5);
        check("armed_ignores_tick", pulse_cnt, 32'd6);
        check("armed_state", {30'b0, state}, 32'd2);

        // STEP: bouncing press then hold gives exactly one pulse
        step_btn = 1'b1; step(1);
        step_btn = 1'b0; step(1);
        step_btn = 1'b1; step(1);
        step_btn = 1'b0; step(1);
        step_btn = 1'b1;
        step(20);
        check("step_pulses", pulse_cnt, 32'd7);
        check("step_held_state", {30'b0, state}, 32'd3);
        check("step_step_count", step_count, 32'd7);
        step_btn = 1'b0;
        step(2);
        check("release_not_debounced", {30'b0, state}, 32'd3);
        step(12);
        check("release_rearmed", {30'b0, state}, 32'd2);
        check("release_no_pulse", pulse_cnt, 32'd7);

        // counter wrap
        mode = 2'b01;
        step(3);
        check("wrap_run_state", {30'b0, state}, 32'd1);
        force dut.step_count = 32'hFFFF_FFFF;
        step(1);
        release dut.step_count;
        step(1);
        check("wrap_preload", step_count, 32'hFFFF_FFFF);
        tick_in = 1'b1;
        step(6);
        check("wrap_step_count", step_count, 32'd0);
        check("wrap_pulses", pulse_cnt, 32'd8);
        tick_in = 1'b0;
        step(10);

        // async reset just after an enable rises
        tick_in = 1'b1;
        step(3);
        @(posedge clk);
        #1;
        check("pre_reset_pulse", {31'b0, cpu_en}, 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_cpu_en", {31'b0, cpu_en}, 32'd0);
        check("async_rst_step_count", step_count, 32'd0);
        check("async_rst_state", {30'b0, state}, 32'd0);
        step(4);
        rst = 1'b0;
        base = pulse_cnt;
        step(12);
        check("no_pulse_tick_high_at_release", pulse_cnt, base);
        check("post_reset_run_state", {30'b0, state}, 32'd1);
        tick_in = 1'b0;
        step(5);
        tick_in = 1'b1;
        rc = cyc;
        step(6);
        check("post_reset_pulse", pulse_cnt, base + 1);
        check("post_reset_latency", last_pulse_cyc - rc, 32'd4);
        check("post_reset_step_count", step_count, 32'd1);

        check("no_back_to_back_enables", consec_err, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
